// File: rtl/ram_arb_2p_if.sv
// rtl/ram_arb_2p_if.sv - requester-side bus of the two-port RAM arbiter
interface ram_arb_2p_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          req0, req1;
  logic          wr0, wr1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          err0, err1;

  modport master (
    output req0, req1, wr0, wr1, a0, a1, d0, d1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );

  modport slave (
    input  req0, req1, wr0, wr1, a0, a1, d0, d1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );
endinterface

// File: rtl/ram_arb_2p.sv
// rtl/ram_arb_2p.sv - two-requester arbiter in front of a single-port RAM
// Optional macro RAM_ARB_FIXED_PRIO_EN: requester 0 always wins, no round-robin pointer.
module ram_arb_2p #(
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  ram_arb_2p_if.slave   io_bus,
  output logic          o_ram_en,
  output logic          o_ram_wr,
  output logic [AW-1:0] o_ram_a,
  output logic [DW-1:0] o_ram_d,
  input  logic [DW-1:0] i_ram_q
);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic          w_gnt0, w_gnt1, w_any, w_wr, w_inr;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt0 = !i_rst && io_bus.req0;
    w_gnt1 = !i_rst && io_bus.req1 && !io_bus.req0;
  end
`else
  // r_ptr names the favoured requester under contention
  logic r_ptr;

  always_comb begin
    w_gnt0 = !i_rst && io_bus.req0 && (!io_bus.req1 || !r_ptr);
    w_gnt1 = !i_rst && io_bus.req1 && (!io_bus.req0 || r_ptr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_ptr <= 1'b0;
    else if (w_gnt0) r_ptr <= 1'b1;
    else if (w_gnt1) r_ptr <= 1'b0;
  end
`endif

  assign w_any = w_gnt0 | w_gnt1;
  assign w_wr  = w_gnt1 ? io_bus.wr1 : io_bus.wr0;
  assign w_a   = w_gnt1 ? io_bus.a1  : io_bus.a0;
  assign w_d   = w_gnt1 ? io_bus.d1  : io_bus.d0;
  assign w_inr = {1'b0, w_a} < LP_DEPTH;

  logic          r_ram_en, r_ram_wr;
  logic [AW-1:0] r_ram_a;
  logic [DW-1:0] r_ram_d;
  logic          r_err0, r_err1;
  logic          r_s1_rd, r_s1_own, r_s1_oor;
  logic          r_rv0, r_rv1, r_s2_oor;

  // Stage 1 issues the RAM command; stage 2 lines up with RAM_Q and returns it to its owner
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ram_en <= 1'b0;
      r_ram_wr <= 1'b0;
      r_ram_a  <= '0;
      r_ram_d  <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_s1_rd  <= 1'b0;
      r_s1_own <= 1'b0;
      r_s1_oor <= 1'b0;
      r_rv0    <= 1'b0;
      r_rv1    <= 1'b0;
      r_s2_oor <= 1'b0;
    end else begin
      r_ram_en <= w_any & w_inr;
      r_ram_wr <= w_any & w_inr & w_wr;
      if (w_any) begin
        r_ram_a <= w_a;
        r_ram_d <= w_d;
      end
      r_err0   <= w_gnt0 & !w_inr;
      r_err1   <= w_gnt1 & !w_inr;
      r_s1_rd  <= w_any & !w_wr;
      r_s1_own <= w_gnt1;
      r_s1_oor <= !w_inr;
      r_rv0    <= r_s1_rd & !r_s1_own;
      r_rv1    <= r_s1_rd & r_s1_own;
      r_s2_oor <= r_s1_oor;
    end
  end

  assign io_bus.gnt0    = w_gnt0;
  assign io_bus.gnt1    = w_gnt1;
  assign io_bus.err0    = r_err0;
  assign io_bus.err1    = r_err1;
  assign io_bus.rvalid0 = r_rv0;
  assign io_bus.rvalid1 = r_rv1;
  assign io_bus.rdata0  = (r_rv0 && !r_s2_oor) ? i_ram_q : '0;
  assign io_bus.rdata1  = (r_rv1 && !r_s2_oor) ? i_ram_q : '0;

  assign o_ram_en = r_ram_en;
  assign o_ram_wr = r_ram_wr;
  assign o_ram_a  = r_ram_a;
  assign o_ram_d  = r_ram_d;
endmodule
